gene_stepper: RTL



---
 rtl/gene_stepper.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/gene_stepper.sv
// Boolean gene-network stepper: iterates x <- f(x) under per-gene activator/inhibitor masks,
// handing each state downstream over a valid/ready handshake until a fixed point or step limit.
module gene_stepper #(
    parameter int unsigned N         = 8,
    parameter int unsigned MAX_STEPS = 16,
    parameter int unsigned CW        = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_we_i,
    input  logic [$clog2(N)-1:0] cfg_idx_i,
    input  logic [N-1:0]         cfg_act_i,
    input  logic [N-1:0]         cfg_inh_i,
    input  logic                 start_i,
    input  logic [N-1:0]         init_i,
    input  logic                 abort_i,
    output logic [N-1:0]         x_o,
    output logic                 x_valid_o,
    input  logic                 x_ready_i,
    output logic [CW-1:0]        step_o,
    output logic                 done_o,
    output logic                 fixed_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   act_q [N];
    logic [N-1:0]   inh_q [N];
    logic [N-1:0]   x_q, x_d, next_x;
    logic [CW-1:0]  step_q, step_d;
    logic           valid_q, valid_d;
    logic           done_q, done_d;
    logic           fixed_q, fixed_d;
    logic           xfer, at_fixed, at_limit, cfg_ok;

    assign xfer     = (state_q == StRun) && valid_q && x_ready_i;
    assign at_fixed = (next_x == x_q);
    assign at_limit = (step_q == CW'(MAX_STEPS - 1));
    assign cfg_ok   = (state_q == StIdle) && cfg_we_i && (32'(cfg_idx_i) < N);

    // A gene with an empty activator mask holds its own value unless inhibited.
    always_comb begin
        next_x = '0;
        for (int i = 0; i < N; i++) begin
            next_x[i] = ((act_q[i] != '0) ? |(x_q & act_q[i]) : x_q[i])
                        & ~|(x_q & inh_q[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                act_q[i] <= '0;
                inh_q[i] <= '0;
            end
        end else if (cfg_ok) begin
            act_q[cfg_idx_i] <= cfg_act_i;
            inh_q[cfg_idx_i] <= cfg_inh_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (start_i) state_d = StRun;
                StRun:   if (xfer && (at_fixed || at_limit)) state_d = StDone;
                StDone:  if (start_i) state_d = StRun;
                default: state_d = StIdle;
            endcase
        end
    end

    // Abort outranks start, and start outranks a transfer (start is only honoured outside RUN).
    always_comb begin
        x_d     = x_q;
        step_d  = step_q;
        valid_d = valid_q;
        done_d  = done_q;
        fixed_d = fixed_q;
        if (abort_i) begin
            valid_d = 1'b0;
            done_d  = 1'b0;
            fixed_d = 1'b0;
        end else if (start_i && (state_q != StRun)) begin
            x_d     = init_i;
            step_d  = '0;
            valid_d = 1'b1;
            done_d  = 1'b0;
            fixed_d = 1'b0;
        end else if (xfer) begin
            if (at_fixed) begin
                valid_d = 1'b0;
                done_d  = 1'b1;
                fixed_d = 1'b1;
            end else if (at_limit) begin
                x_d     = next_x;
                step_d  = CW'(MAX_STEPS);
                valid_d = 1'b0;
                done_d  = 1'b1;
                fixed_d = 1'b0;
            end else begin
                x_d    = next_x;
                step_d = step_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            step_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            fixed_q <= 1'b0;
        end else begin
            x_q     <= x_d;
            step_q  <= step_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            fixed_q <= fixed_d;
        end
    end

    assign x_o       = x_q;
    assign step_o    = step_q;
    assign x_valid_o = valid_q;
    assign done_o    = done_q;
    assign fixed_o   = fixed_q;

endmodule
